// File: rtl/image_stream_tx_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the image transmit path.
package image_stream_tx_pkg;

    localparam int IMG_WIDTH       = 410;
    localparam int IMG_HEIGHT      = 361;
    localparam int IMG_RESIZE_SIZE = 3;
    localparam int IMG_PIX_W       = 8;
    localparam int IMG_ADDR_W      = 18;

    // sof, eol, eof travel with every pixel
    localparam int FLAG_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/image_stream_tx_if.sv
// Valid/ready pixel stream with frame qualifiers; master drives pixels, slave drives ready.
interface image_stream_tx_if
    import image_stream_tx_pkg::*;
#(
    parameter int PIX_W = IMG_PIX_W
);

    logic [PIX_W-1:0] image_output;
    logic             out_valid;
    logic             out_ready;
    logic             sof;
    logic             eol;
    logic             eof;

    modport master (
        output image_output, out_valid, sof, eol, eof,
        input  out_ready
    );

    modport slave (
        input  image_output, out_valid, sof, eol, eof,
        output out_ready
    );

endinterface

// File: rtl/pix_fifo2.sv
// Two-entry FIFO with occupancy count; push while full is accepted only alongside a pop.
module pix_fifo2 #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/image_stream_tx.sv
// Streams a buffered grayscale frame row-major, optionally nearest-neighbour upsampled,
// with a credit-limited read pipeline into a 2-entry FIFO.
module image_stream_tx
    import image_stream_tx_pkg::*;
#(
    parameter int WIDTH       = IMG_WIDTH,
    parameter int HEIGHT      = IMG_HEIGHT,
    parameter int RESIZE_SIZE = IMG_RESIZE_SIZE,
    parameter int PIX_W       = IMG_PIX_W,
    parameter int ADDR_W      = IMG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              scale,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              finish,
    image_stream_tx_if.master tx
);

    localparam int COL_W  = cnt_w(WIDTH);
    localparam int ROW_W  = cnt_w(HEIGHT);
    localparam int K_W    = cnt_w(RESIZE_SIZE);
    localparam int ENT_W  = PIX_W + FLAG_W;
    localparam int EOF_BIT = PIX_W;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [K_W-1:0]    K_UP     = K_W'(RESIZE_SIZE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

    state_e            state_q, state_d;
    logic              scale_q, scale_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [K_W-1:0]    kx_q, kx_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [K_W-1:0]    ky_q, ky_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              inflight_q, inflight_d;
    logic [FLAG_W-1:0] iflags_q, iflags_d;

    logic [K_W-1:0]    k_last;
    logic              rd_sof, rd_eol, rd_eof;
    logic [ENT_W-1:0]  fifo_din, fifo_dout;
    logic [1:0]        fifo_count;
    logic [2:0]        in_use;
    logic              credit_ok;
    logic              pop;

    assign k_last = scale_q ? K_UP : '0;

    // Qualifiers belong to the output pixel this read will become.
    assign rd_sof = (row_q == '0) && (ky_q == '0) && (col_q == '0) && (kx_q == '0);
    assign rd_eol = (col_q == COL_LAST) && (kx_q == k_last);
    assign rd_eof = rd_eol && (row_q == ROW_LAST) && (ky_q == k_last);

    assign pop    = tx.out_valid && tx.out_ready;
    assign in_use = {1'b0, fifo_count} + {2'b00, inflight_q};
    // A pop in this cycle frees a slot in time for the read issued now, which keeps 1 pixel/clk.
    assign credit_ok = (in_use < 3'd2) || pop;

    assign rd_en   = (state_q == ST_STREAM) && credit_ok;
    assign rd_addr = row_base_q + ADDR_W'(col_q);

    always_comb begin
        state_d    = state_q;
        scale_d    = scale_q;
        col_d      = col_q;
        kx_d       = kx_q;
        row_d      = row_q;
        ky_d       = ky_q;
        row_base_d = row_base_q;
        inflight_d = rd_en;
        iflags_d   = {rd_sof, rd_eol, rd_eof};

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_STREAM;
                    scale_d    = scale;
                    col_d      = '0;
                    kx_d       = '0;
                    row_d      = '0;
                    ky_d       = '0;
                    row_base_d = '0;
                end
            end
            ST_STREAM: begin
                if (rd_en) begin
                    if (kx_q == k_last) begin
                        kx_d = '0;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (ky_q == k_last) begin
                                ky_d = '0;
                                if (row_q == ROW_LAST) begin
                                    row_d      = '0;
                                    row_base_d = '0;
                                end else begin
                                    row_d      = row_q + 1'b1;
                                    row_base_d = row_base_q + ROW_STEP;
                                end
                            end else begin
                                ky_d = ky_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        kx_d = kx_q + 1'b1;
                    end
                    if (rd_eof) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_dout[EOF_BIT]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            scale_q    <= 1'b0;
            col_q      <= '0;
            kx_q       <= '0;
            row_q      <= '0;
            ky_q       <= '0;
            row_base_q <= '0;
            inflight_q <= 1'b0;
            iflags_q   <= '0;
        end else begin
            state_q    <= state_d;
            scale_q    <= scale_d;
            col_q      <= col_d;
            kx_q       <= kx_d;
            row_q      <= row_d;
            ky_q       <= ky_d;
            row_base_q <= row_base_d;
            inflight_q <= inflight_d;
            iflags_q   <= iflags_d;
        end
    end

    // rd_data lands one cycle after rd_en, together with the flags captured at issue.
    assign fifo_din = {iflags_q, rd_data};

    pix_fifo2 #(
        .DW(ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign tx.out_valid    = (fifo_count != 2'd0);
    assign tx.image_output = tx.out_valid ? fifo_dout[PIX_W-1:0] : '0;
    assign tx.sof          = tx.out_valid && fifo_dout[ENT_W-1];
    assign tx.eol          = tx.out_valid && fifo_dout[ENT_W-2];
    assign tx.eof          = tx.out_valid && fifo_dout[EOF_BIT];

    assign busy   = (state_q != ST_IDLE);
    assign finish = (state_q == ST_DONE);

endmodule

// File: tb/tb_image_stream_tx.sv
// Scoreboard bench for image_stream_tx on a 4x3 frame with x2 replication.
`timescale 1ns/1ps
module tb_image_stream_tx;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int R  = 2;
    localparam int PW = 8;
    localparam int AW = 8;

    typedef struct packed {
        logic          sof;
        logic          eol;
        logic          eof;
        logic [PW-1:0] pix;
    } ent_t;

    typedef struct {
        bit scale;
        int rdy_pct;
        int exp_n;
        int exp_last;
        bit chk_gap;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          scale = 1'b0;
    logic          rd_en, busy, finish;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data = '0;

    image_stream_tx_if #(.PIX_W(PW)) bus ();

    image_stream_tx #(
        .WIDTH(W), .HEIGHT(H), .RESIZE_SIZE(R), .PIX_W(PW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scale(scale),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .finish(finish), .tx(bus)
    );

    always #5 clk = ~clk;

    // Frame buffer holding pixel = address, one-cycle read latency.
    always @(posedge clk) if (rd_en) rd_data <= PW'(rd_addr);

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_xfer, gaps, n_finish, n_rd, first_valid_cyc, eof_cyc, finish_cyc, start_cyc;
    int last_pix;
    bit saw_eof;
    bit prev_hold = 1'b0;
    ent_t prev_ent, first_ent;
    ent_t exp_q[$];
    vec_t vecs[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic longint outs_vec();
        return longint'({rd_en, rd_addr, busy, finish, bus.out_valid,
                         bus.sof, bus.eol, bus.eof, bus.image_output});
    endfunction

    task automatic clr_stats();
        n_xfer = 0; gaps = 0; n_finish = 0; n_rd = 0; first_valid_cyc = -1;
        eof_cyc = -1; finish_cyc = -1; saw_eof = 0; last_pix = 0; first_ent = '0;
    endtask

    task automatic push_frame(input bit sc);
        int f, ow, oh;
        ent_t e;
        f  = sc ? R : 1;
        ow = W * f;
        oh = H * f;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                e.pix = PW'((oy / f) * W + (ox / f));
                e.sof = (ox == 0) && (oy == 0);
                e.eol = (ox == ow - 1);
                e.eof = (ox == ow - 1) && (oy == oh - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input bit sc);
        start = 1'b1;
        scale = sc;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int pct);
        int t;
        t = 0;
        while (!finish && t < 2000) begin
            bus.out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            @(posedge clk);
            #1;
            t++;
        end
        chk("finish_seen", longint'(finish), 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        ent_t cur, e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            cur = {bus.sof, bus.eol, bus.eof, bus.image_output};
            if (prev_hold)
                chk("hold_stable", longint'({bus.out_valid, cur}), longint'({1'b1, prev_ent}));
            if (rd_en) n_rd++;
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (busy && first_valid_cyc >= 0 && !saw_eof && bus.out_ready && !bus.out_valid) gaps++;
            if (bus.out_valid && bus.out_ready) begin
                chk("expected_queue_nonempty", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pixel", longint'(cur), longint'(e));
                end
                if (n_xfer == 0) first_ent = cur;
                n_xfer++;
                last_pix = int'(bus.image_output);
                if (bus.eof) begin
                    saw_eof = 1'b1;
                    eof_cyc = cyc;
                end
            end
            if (finish) begin
                n_finish++;
                finish_cyc = cyc;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_ent  = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        int t, busy_low;
        bus.out_ready = 1'b0;
        vecs[0] = '{scale: 1'b0, rdy_pct: 100, exp_n: 12, exp_last: 11, chk_gap: 1'b1};
        vecs[1] = '{scale: 1'b1, rdy_pct: 100, exp_n: 48, exp_last: 11, chk_gap: 1'b1};
        vecs[2] = '{scale: 1'b1, rdy_pct: 50,  exp_n: 48, exp_last: 11, chk_gap: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs_vec(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", longint'({busy, bus.out_valid, rd_en}), 0);

        foreach (vecs[i]) begin
            clr_stats();
            bus.out_ready = 1'b1;
            push_frame(vecs[i].scale);
            pulse_start(vecs[i].scale);
            wait_done(vecs[i].rdy_pct);
            chk("frame_pixel_count", n_xfer, vecs[i].exp_n);
            chk("frame_last_pixel", last_pix, vecs[i].exp_last);
            chk("first_valid_latency", first_valid_cyc - start_cyc, 2);
            chk("finish_after_eof", finish_cyc - eof_cyc, 1);
            chk("finish_pulses", n_finish, 1);
            chk("queue_drained", exp_q.size(), 0);
            if (vecs[i].chk_gap) chk("no_bubbles", gaps, 0);
            chk("idle_after_frame", longint'(busy), 0);
        end

        // Extra start mid-frame and in the finish cycle
        clr_stats();
        bus.out_ready = 1'b1;
        push_frame(1'b0);
        pulse_start(1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; scale = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_low = 0;
        t = 0;
        while (!finish && t < 2000) begin
            if (!busy) busy_low++;
            @(posedge clk);
            #1;
            t++;
        end
        chk("t4_finish_seen", longint'(finish), 1);
        start = 1'b1; scale = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t4_pixel_count", n_xfer, 12);
        chk("t4_busy_held", busy_low, 0);
        chk("t4_finish_pulses", n_finish, 1);
        chk("t4_idle", longint'({busy, bus.out_valid}), 0);
        chk("t4_queue_drained", exp_q.size(), 0);

        // Asynchronous reset mid-frame
        clr_stats();
        push_frame(1'b0);
        pulse_start(1'b0);
        t = 0;
        while (!(bus.out_valid && bus.image_output == PW'(5)) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("t5_reached_pixel5", longint'(bus.image_output), 5);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_reset_outputs", outs_vec(), 0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clr_stats();
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done(100);
        chk("t5_first_pixel", longint'(first_ent), longint'({1'b1, 1'b0, 1'b0, 8'd0}));
        chk("t5_pixel_count", n_xfer, 12);
        chk("t5_queue_drained", exp_q.size(), 0);

        // Sink stalled right after start
        clr_stats();
        bus.out_ready = 1'b0;
        push_frame(1'b0);
        pulse_start(1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_reads_while_stalled", longint'(n_rd <= 2), 1);
        chk("t6_no_transfer", n_xfer, 0);
        chk("t6_valid_waiting", longint'(bus.out_valid), 1);
        wait_done(100);
        chk("t6_pixel_count", n_xfer, 12);
        chk("t6_no_bubbles", gaps, 0);
        chk("t6_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
